// File: rtl/result_dump_ctrl_pkg.sv
// result_dump_ctrl_pkg: shared FSM encoding, default widths and window sanity check for the result dump path
package result_dump_ctrl_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } dump_state_t;
  // A legal window is word aligned, ordered, reachable in whole steps and fits in the address width.
  function automatic bit window_ok(int aw, int s, int e, int st);
    return (s % 4 == 0) && (e % 4 == 0) && (e >= s) && (st > 0) &&
           ((e - s) % st == 0) && (e < (1 << aw));
  endfunction
endpackage

// File: rtl/result_dump_ctrl_if.sv
// result_dump_ctrl_if: (address, word) valid/ready stream
//   master: drives addr, data, valid; samples ready
//   slave : samples addr, data, valid; drives ready
interface result_dump_ctrl_if
  import result_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  modport master(output addr, data, valid, input ready);
  modport slave(input addr, data, valid, output ready);
endinterface

// File: rtl/result_dump_ctrl_checksum.sv
// result_dump_ctrl_checksum: wrapping accumulator with synchronous clear and add enable
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the sum (wins over en)
//   en, d      : add d to the sum
//   sum        : running sum mod 2^W
module result_dump_ctrl_checksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= sum + d;
endmodule

// File: rtl/result_dump_ctrl.sv
// result_dump_ctrl: after the core halts, walks test_address over a memory window and streams each word out
//   clk, rst_n   : ungated core clock, async active-low reset
//   hlt          : core halt flag (raw, registered once here)
//   result_in    : Result1 from the core for the current test_address
//   test_address : address driven into the halted core
//   dump         : (addr, data) valid/ready stream master
//   busy, done   : walking the window / whole window delivered (held)
//   aborted      : one-cycle pulse when the halt drops mid-dump
//   checksum     : sum mod 2^DATA_W of words handshaken in this dump
module result_dump_ctrl
  import result_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 252,
  parameter int STEP       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic [DATA_W-1:0] result_in,
  output logic [ADDR_W-1:0] test_address,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  result_dump_ctrl_if.master dump
);
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  if (!window_ok(ADDR_W, START_ADDR, END_ADDR, STEP)) begin : g_bad_window
    $error("result_dump_ctrl: dump window misaligned, unordered or wider than ADDR_W");
  end
  dump_state_t state;
  logic        hlt_q;
  logic        xfer;
  // valid is only ever high in SEND, so this is the SEND handshake
  assign xfer = dump.valid & dump.ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      hlt_q        <= 1'b0;
      test_address <= '0;
      dump.addr    <= '0;
      dump.data    <= '0;
      dump.valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      hlt_q   <= hlt;
      aborted <= 1'b0;
      case (state)
        IDLE:
          if (hlt_q) begin
            state        <= SETTLE;
            test_address <= START_A;
            done         <= 1'b0;
            busy         <= 1'b1;
          end
        SETTLE:
          if (!hlt_q) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state      <= SEND;
            dump.data  <= result_in;
            dump.addr  <= test_address;
            dump.valid <= 1'b1;
          end
        SEND:
          if (!hlt_q) begin
            state      <= IDLE;
            dump.valid <= 1'b0;
            busy       <= 1'b0;
            aborted    <= 1'b1;
          end else if (xfer) begin
            dump.valid <= 1'b0;
            if (test_address == END_A) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= SETTLE;
              test_address <= test_address + STEP_A;
            end
          end
        DONE:
          if (!hlt_q) begin
            state <= IDLE;
            done  <= 1'b0;
          end
      endcase
    end
  // A handshake the sink has seen is counted even if the halt drops on the same edge.
  result_dump_ctrl_checksum #(.W(DATA_W)) u_checksum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state == IDLE) & hlt_q),
    .en   (xfer),
    .d    (dump.data),
    .sum  (checksum)
  );
endmodule

// File: tb/tb_result_dump_ctrl.sv
// tb_result_dump_ctrl: scoreboard bench; expected beats are queued per dump, a monitor pops them on each handshake
module tb_result_dump_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int S  = 0;
  localparam int E  = 252;
  localparam int ST = 4;
  localparam int N  = (E - S) / ST + 1;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hlt = 1'b0;
  logic [DW-1:0] result_in;
  logic [AW-1:0] test_address;
  logic          busy, done, aborted;
  logic [DW-1:0] checksum;
  logic [DW-1:0] mem [64];
  beat_t         exp_q [$];
  logic [DW-1:0] exp_sum = '0;
  logic [DW-1:0] first_sum;
  int            rmode = 0;
  int            vectors = 0;
  int            miscompares = 0;
  result_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dump_if ();
  result_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(S), .END_ADDR(E), .STEP(ST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hlt         (hlt),
    .result_in   (result_in),
    .test_address(test_address),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .checksum    (checksum),
    .dump        (dump_if)
  );
  always #5 clk = ~clk;
  assign result_in = mem[test_address[AW-1:2]];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    int c = 0;
    dump_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      c++;
      case (rmode)
        0: dump_if.ready = 1'b1;
        1: dump_if.ready = (c % 4 == 0);
        2: dump_if.ready = 1'($urandom_range(0, 1));
        default: dump_if.ready = (dump_if.addr != 8'd8);
      endcase
    end
  end
  initial begin
    logic          prev_vnr = 1'b0;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_vnr = 1'b0;
      else begin
        if (prev_vnr && !aborted) begin
          chk("hold_valid", dump_if.valid, 1);
          chk("hold_addr", dump_if.addr, prev_a);
          chk("hold_data", dump_if.data, prev_d);
        end
        if (dump_if.valid && dump_if.ready) begin
          if (exp_q.size() == 0) chk("beat_unexpected", dump_if.addr, 64'hdead);
          else begin
            b = exp_q.pop_front();
            chk("beat_addr", dump_if.addr, b.addr);
            chk("beat_data", dump_if.data, b.data);
            exp_sum += b.data;
          end
        end
        prev_vnr = dump_if.valid && !dump_if.ready;
        prev_a   = dump_if.addr;
        prev_d   = dump_if.data;
      end
    end
  end
  task automatic fill_pattern();
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
  endtask
  task automatic fill_random();
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
  endtask
  task automatic queue_dump();
    exp_sum = '0;
    for (int k = 0; k < N; k++) exp_q.push_back('{addr: AW'(S + k * ST), data: mem[(S + k * ST) / 4]});
  endtask
  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, done, 1);
    @(negedge clk);
    chk({nm, "_sum"}, checksum, exp_sum);
    chk({nm, "_all_beats"}, exp_q.size(), 0);
    chk({nm, "_addr_end"}, test_address, E);
    chk({nm, "_busy"}, busy, 0);
  endtask
  task automatic run_dump(string nm);
    queue_dump();
    hlt = 1'b1;
    wait_done(nm);
  endtask
  task automatic release_hlt(string nm);
    hlt = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_done_clear"}, done, 0);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask
  initial begin
    int n;
    fill_pattern();
    repeat (3) @(negedge clk);
    chk("rst_taddr", test_address, 0);
    chk("rst_valid", dump_if.valid, 0);
    chk("rst_daddr", dump_if.addr, 0);
    chk("rst_data", dump_if.data, 0);
    chk("rst_flags", {busy, done, aborted}, 0);
    chk("rst_sum", checksum, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rmode = 0;
    run_dump("pattern_tied");
    chk("pattern_sum_const", checksum, 32'h0000_07E0);
    first_sum = exp_sum;
    release_hlt("pattern_tied");
    rmode = 1;
    run_dump("pattern_gappy");
    chk("pattern_sum_repeat", checksum, first_sum);
    release_hlt("pattern_gappy");
    fill_random();
    rmode = 2;
    run_dump("random_ready");
    release_hlt("random_ready");
    fill_pattern();
    rmode = 3;
    queue_dump();
    hlt = 1'b1;
    n = 0;
    while (!(dump_if.valid && dump_if.addr == 8'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_8", dump_if.addr, 8);
    @(negedge clk);
    hlt = 1'b0;
    n = 0;
    while (!aborted && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("abort_pulse", aborted, 1);
    chk("abort_valid", dump_if.valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", checksum, 32'h2000_0001);
    chk("abort_sum_model", checksum, exp_sum);
    exp_q.delete();
    @(negedge clk);
    chk("abort_pulse_end", aborted, 0);
    rmode = 0;
    repeat (2) @(negedge clk);
    #1 hlt = 1'b1;
    #2 hlt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("glitch_busy", busy, 0);
      chk("glitch_valid", dump_if.valid, 0);
    end
    fill_random();
    queue_dump();
    hlt = 1'b1;
    n = 0;
    while (!(busy && !dump_if.valid && test_address == 8'd16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("areset_settle", test_address, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_taddr", test_address, 0);
    chk("areset_stream", {dump_if.valid, dump_if.addr, dump_if.data}, 0);
    chk("areset_flags", {busy, done, aborted}, 0);
    chk("areset_sum", checksum, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    queue_dump();
    rst_n = 1'b1;
    wait_done("areset_fresh");
    release_hlt("areset_fresh");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
